// File: rtl/mem_sram_ctrl.sv
// MEM-stage controller for a 16-bit asynchronous SRAM: every 32-bit load or
// store becomes two halfword accesses (low half, then high half).
//
// state | meaning
// IDLE  | no access; a request is latched and the access starts next cycle
// LO    | low halfword access, WAIT_CYCLES cycles
// HI    | high halfword access, WAIT_CYCLES cycles
// DONE  | single cycle with ready high; rdata already holds the load result
module mem_sram_ctrl #(
    parameter int          WAIT_CYCLES = 4,
    parameter logic [31:0] BASE_ADDR   = 32'd1024,
    parameter int          ADDR_W      = 18
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MEM_R_EN,
    input  logic              MEM_W_EN,
    input  logic [31:0]       address,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              ready,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [15:0]       sram_dq_out,
    input  logic [15:0]       sram_dq_in,
    output logic              sram_dq_oe,
    output logic              sram_we_n
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LO,
        S_HI,
        S_DONE
    } state_t;

    localparam logic [3:0] CNT_LAST = 4'(WAIT_CYCLES - 1);

    state_t            state;
    state_t            state_nxt;
    logic [3:0]        cnt;
    logic [3:0]        cnt_nxt;
    logic              req;
    logic              phase_end;
    logic              in_phase;
    logic              op_write;
    logic [15:0]       wdata_hi;
    logic [ADDR_W-2:0] word_idx;
    logic [ADDR_W-2:0] word_new;
    logic [15:0]       lo_buf;
    logic [31:0]       offset;
    logic              unused_offset_bits;

    assign req       = MEM_R_EN | MEM_W_EN;
    assign phase_end = (cnt == CNT_LAST);
    assign in_phase  = (state == S_LO) || (state == S_HI);

    // Addresses below BASE_ADDR simply wrap; the dropped bits carry no error.
    assign offset             = address - BASE_ADDR;
    assign word_new           = offset[ADDR_W:2];
    assign unused_offset_bits = ^{offset[31:ADDR_W+1], offset[1:0]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ready     = 1'b0;
        case (state)
            S_IDLE: begin
                ready   = ~req;
                cnt_nxt = 4'd0;
                if (req) begin
                    state_nxt = S_LO;
                end
            end
            S_LO: begin
                if (phase_end) begin
                    state_nxt = S_HI;
                    cnt_nxt   = 4'd0;
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            S_HI: begin
                if (phase_end) begin
                    state_nxt = S_DONE;
                    cnt_nxt   = 4'd0;
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            S_DONE: begin
                ready     = 1'b1;
                state_nxt = S_IDLE;
                cnt_nxt   = 4'd0;
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = 4'd0;
            end
        endcase
    end

    // Strobe is released on the last cycle of each phase so the address
    // never moves while WE is active.
    assign sram_dq_oe = in_phase & op_write;
    assign sram_we_n  = ~(in_phase & op_write & (cnt < CNT_LAST));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_write    <= 1'b0;
            wdata_hi    <= 16'd0;
            word_idx    <= '0;
            lo_buf      <= 16'd0;
            rdata       <= 32'd0;
            sram_addr   <= '0;
            sram_dq_out <= 16'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req) begin
                        op_write  <= MEM_W_EN;
                        wdata_hi  <= wdata[31:16];
                        word_idx  <= word_new;
                        sram_addr <= {word_new, 1'b0};
                        if (MEM_W_EN) begin
                            sram_dq_out <= wdata[15:0];
                        end
                    end
                end
                S_LO: begin
                    if (phase_end) begin
                        sram_addr <= {word_idx, 1'b1};
                        if (op_write) begin
                            sram_dq_out <= wdata_hi;
                        end else begin
                            lo_buf <= sram_dq_in;
                        end
                    end
                end
                S_HI: begin
                    if (phase_end && !op_write) begin
                        rdata <= {sram_dq_in, lo_buf};
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_sram_ctrl.sv
// Bench for mem_sram_ctrl: pad-level SRAM model, transaction-level reference
// model checked every cycle, plus directed scenarios with literal expectations.
module tb_mem_sram_ctrl;

    localparam int W = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        MEM_R_EN = 1'b0;
    logic        MEM_W_EN = 1'b0;
    logic [31:0] address = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic [31:0] rdata;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out;
    logic [15:0] sram_dq_in;
    logic        sram_dq_oe;
    logic        sram_we_n;

    mem_sram_ctrl #(
        .WAIT_CYCLES(W),
        .BASE_ADDR  (32'd1024),
        .ADDR_W     (18)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .MEM_R_EN   (MEM_R_EN),
        .MEM_W_EN   (MEM_W_EN),
        .address    (address),
        .wdata      (wdata),
        .rdata      (rdata),
        .ready      (ready),
        .sram_addr  (sram_addr),
        .sram_dq_out(sram_dq_out),
        .sram_dq_in (sram_dq_in),
        .sram_dq_oe (sram_dq_oe),
        .sram_we_n  (sram_we_n)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Pad-level SRAM: only the low 8 halfword-address bits are decoded.
    logic [15:0] pad_mem [0:255] = '{default: 16'h0000};
    int          pad_writes = 0;
    assign sram_dq_in = pad_mem[sram_addr[7:0]];

    always @(negedge clk) begin
        if (!sram_we_n) begin
            pad_mem[sram_addr[7:0]] = sram_dq_out;
            pad_writes++;
        end
    end

    // Reference model: position within the current access, counted in cycles
    // after the request was accepted (-1 = no access in progress).
    int          mk;
    logic        m_wr;
    logic [16:0] m_word;
    logic [31:0] m_wdata;
    logic [31:0] exp_rdata;
    logic [17:0] exp_addr;
    logic [15:0] ref_mem [0:255] = '{default: 16'h0000};

    function automatic logic [16:0] word_of(input logic [31:0] a);
        logic [31:0] diff;
        diff = (a - 32'd1024) >> 2;
        return diff[16:0];
    endfunction

    always @(posedge clk or negedge rst) begin
        logic [17:0] ha;
        if (!rst) begin
            mk        = -1;
            exp_rdata = 32'd0;
            exp_addr  = 18'd0;
        end else if (mk < 0) begin
            if (MEM_R_EN || MEM_W_EN) begin
                mk       = 1;
                m_wr     = MEM_W_EN;
                m_word   = word_of(address);
                m_wdata  = wdata;
                exp_addr = {m_word, 1'b0};
            end
        end else if (mk == 2 * W + 1) begin
            mk = -1;
        end else begin
            mk++;
            if (mk == W + 1) exp_addr = {m_word, 1'b1};
            if (mk == 2 * W + 1) begin
                ha = {m_word, 1'b0};
                if (m_wr) begin
                    ref_mem[ha[7:0]]        = m_wdata[15:0];
                    ref_mem[ha[7:0] + 8'd1] = m_wdata[31:16];
                end else begin
                    exp_rdata = {ref_mem[ha[7:0] + 8'd1], ref_mem[ha[7:0]]};
                end
            end
        end
    end

    always @(negedge clk) begin
        logic        ph;
        logic        e_ready;
        logic        e_we_n;
        logic [17:0] ha;
        if (rst === 1'b1) begin
            ph      = (mk >= 1) && (mk <= 2 * W);
            e_ready = (mk < 0) ? !(MEM_R_EN || MEM_W_EN) : (mk == 2 * W + 1);
            e_we_n  = !(m_wr && ph && (((mk - 1) % W) < W - 1));
            check("ready", ready, e_ready);
            check("we_n", sram_we_n, e_we_n);
            check("dq_oe", sram_dq_oe, m_wr && ph);
            check("rdata", rdata, exp_rdata);
            check("sram_addr", sram_addr, exp_addr);
            if (ph && m_wr)
                check("dq_out", sram_dq_out, (mk <= W) ? m_wdata[15:0] : m_wdata[31:16]);
            if (mk == 2 * W + 1 && m_wr) begin
                ha = {m_word, 1'b0};
                check("pad_lo", pad_mem[ha[7:0]], m_wdata[15:0]);
                check("pad_hi", pad_mem[ha[7:0] + 8'd1], m_wdata[31:16]);
            end
        end
    end

    task automatic start(input logic r, input logic w, input logic [31:0] a,
                         input logic [31:0] d, output int t);
        @(posedge clk);
        #1;
        MEM_R_EN = r;
        MEM_W_EN = w;
        address  = a;
        wdata    = d;
        t        = cyc;
    endtask

    task automatic wait_done(output int lat, output int we_low, output int t_done);
        lat    = 0;
        we_low = 0;
        @(negedge clk);
        while (!ready && lat < 100) begin
            lat++;
            if (!sram_we_n) we_low++;
            @(negedge clk);
        end
        t_done = cyc;
    endtask

    task automatic drop();
        @(posedge clk);
        #1;
        MEM_R_EN = 1'b0;
        MEM_W_EN = 1'b0;
    endtask

    initial begin
        int t0, t1, lat, we_low, t_done, snap, rlow, wlow, oeh;
        #2;
        check("rst_ready", ready, 1'b1);
        check("rst_we_n", sram_we_n, 1'b1);
        check("rst_oe", sram_dq_oe, 1'b0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_addr", sram_addr, 18'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        start(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, t0);
        wait_done(lat, we_low, t_done);
        check("st0_ready_low", lat, 9);
        check("st0_we_low", we_low, 6);
        check("st0_done_at", t_done - t0, 9);
        check("st0_mem0", pad_mem[0], 16'hBEEF);
        check("st0_mem1", pad_mem[1], 16'hDEAD);
        drop();

        start(1'b1, 1'b0, 32'd1024, 32'h0, t0);
        wait_done(lat, we_low, t_done);
        check("ld0_rdata", rdata, 32'hDEADBEEF);
        check("ld0_done_at", t_done - t0, 9);
        check("ld0_we_low", we_low, 0);
        drop();

        start(1'b0, 1'b1, 32'd1028, 32'h12345678, t0);
        wait_done(lat, we_low, t_done);
        start(1'b1, 1'b0, 32'd1028, 32'h0, t1);
        check("b2b_start", t1 - t0, 10);
        wait_done(lat, we_low, t_done);
        check("b2b_rdata", rdata, 32'h12345678);
        check("b2b_mem2", pad_mem[2], 16'h5678);
        check("b2b_mem3", pad_mem[3], 16'h1234);
        drop();

        snap = pad_writes;
        rlow = 0; wlow = 0; oeh = 0;
        repeat (20) begin
            @(negedge clk);
            if (!ready) rlow++;
            if (!sram_we_n) wlow++;
            if (sram_dq_oe) oeh++;
        end
        check("idle_ready_low", rlow, 0);
        check("idle_we_low", wlow, 0);
        check("idle_oe_high", oeh, 0);
        check("idle_writes", pad_writes - snap, 0);

        start(1'b1, 1'b1, 32'd1032, 32'hCAFEF00D, t0);
        wait_done(lat, we_low, t_done);
        check("both_mem4", pad_mem[4], 16'hF00D);
        check("both_mem5", pad_mem[5], 16'hCAFE);
        check("both_rdata", rdata, 32'h12345678);
        drop();

        start(1'b0, 1'b1, 32'd1020, 32'h0BADF00D, t0);
        @(negedge clk);
        @(negedge clk);
        check("wrap_addr", sram_addr, 18'h3FFFE);
        wait_done(lat, we_low, t_done);
        check("wrap_mem254", pad_mem[254], 16'hF00D);
        check("wrap_mem255", pad_mem[255], 16'h0BAD);
        drop();

        start(1'b0, 1'b1, 32'd1036, 32'hAAAA5555, t0);
        repeat (W + 2) @(negedge clk);
        check("hi_we_n_pre", sram_we_n, 1'b0);
        check("hi_addr_pre", sram_addr, 18'd7);
        #1 rst = 1'b0;
        #1;
        check("mid_rst_we_n", sram_we_n, 1'b1);
        check("mid_rst_oe", sram_dq_oe, 1'b0);
        check("mid_rst_rdata", rdata, 32'd0);
        check("mid_rst_addr", sram_addr, 18'd0);
        check("mid_rst_dq_out", sram_dq_out, 16'd0);
        check("mid_rst_ready", ready, 1'b0);
        @(posedge clk);
        #1 rst = 1'b1;
        wait_done(lat, we_low, t_done);
        check("post_rst_lat", lat, 9);
        check("post_rst_we_low", we_low, 6);
        drop();

        start(1'b1, 1'b0, 32'd1036, 32'h0, t0);
        wait_done(lat, we_low, t_done);
        check("post_rst_rdata", rdata, 32'hAAAA5555);
        drop();

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
